// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Latency: none, wires only.
// Backpressure: none; start is sampled only while the subtractor is not busy.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a-b, LSB first, single borrow flop; diff/borrow/zero held until next result.
// Latency: WIDTH+1 cycles from accepted start to done; one result per WIDTH+1 cycles.
// Backpressure: start ignored while busy; a start in the done cycle chains with no idle gap.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             a0, b0, d_bit, br_next;
    logic [WIDTH-1:0] r_shifted;

    // Full-subtractor cell on the current LSB pair.
    assign a0        = a_sh_q[0];
    assign b0        = b_sh_q[0];
    assign d_bit     = a0 ^ b0 ^ br_q;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign r_shifted = {d_bit, r_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_shifted;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                // Result registers load from the final bit on the same edge that enters DONE.
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = r_shifted;
                    borrow_d = br_next;
                    zero_d   = (r_shifted == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: arithmetic-level model compared every cycle plus literal checks.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: a countdown of remaining serial cycles and a plain a-b result.
    int           m_rem;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_borrow;
    logic         m_zero;
    logic [W-1:0] p_diff;
    logic         p_borrow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_zero   <= 1'b0;
            p_diff   <= '0;
            p_borrow <= 1'b0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_diff   <= p_diff;
                m_borrow <= p_borrow;
                m_zero   <= (p_diff == '0);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                p_diff   <= bus.a - bus.b;
                p_borrow <= (bus.a < bus.b);
                m_rem    <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model busy", 32'(bus.busy), 32'(m_rem != 0));
            chk("model done", 32'(bus.done), 32'(m_done));
            chk("model diff", 32'(bus.diff), 32'(m_diff));
            chk("model borrow", 32'(bus.borrow), 32'(m_borrow));
            chk("model zero", 32'(bus.zero), 32'(m_zero));
        end
        if (bus.done) done_cnt++;
    end

    // Waits for done; n counts falling edges after the start edge (done arrives on the 9th for W=8).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        if (!bus.done) chk("done timeout", 32'(n), 32'(0));
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic ez,
                          input string nm);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        n = 1;
        if (!bus.done) begin
            int k;
            wait_done(k);
            n += k;
        end
        chk({nm, " latency"}, 32'(n), 32'(W + 1));
        chk({nm, " diff"}, 32'(bus.diff), 32'(ed));
        chk({nm, " borrow"}, 32'(bus.borrow), 32'(eb));
        chk({nm, " zero"}, 32'(bus.zero), 32'(ez));
    endtask

    initial begin
        int n;
        int d0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'(0));
        chk("reset done", 32'(bus.done), 32'(0));
        chk("reset diff", 32'(bus.diff), 32'(0));
        chk("reset borrow", 32'(bus.borrow), 32'(0));
        chk("reset zero", 32'(bus.zero), 32'(0));
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "05-03");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "03-05");
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "00-FF");
        run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, "A5-A5");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, "FF-00");

        // Start pulse and operand churn mid-operation must be ignored.
        @(negedge clk);
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        wait_done(n);
        chk("ignore diff", 32'(bus.diff), 32'h0F);
        chk("ignore borrow", 32'(bus.borrow), 32'(0));
        repeat (12) @(negedge clk);
        chk("ignore done pulses", 32'(done_cnt - d0), 32'(1));

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h40;
        bus.b = 8'h01;
        wait_done(n);
        chk("b2b first diff", 32'(bus.diff), 32'h3F);
        bus.a = 8'h80;
        bus.b = 8'h81;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b no idle busy", 32'(bus.busy), 32'(1));
        chk("b2b first held", 32'(bus.diff), 32'h3F);
        wait_done(n);
        chk("b2b spacing", 32'(n + 1), 32'(W + 1));
        chk("b2b second diff", 32'(bus.diff), 32'hFF);
        chk("b2b second borrow", 32'(bus.borrow), 32'(1));

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(bus.busy), 32'(0));
        chk("arst done", 32'(bus.done), 32'(0));
        chk("arst diff", 32'(bus.diff), 32'(0));
        chk("arst borrow", 32'(bus.borrow), 32'(0));
        chk("arst zero", 32'(bus.zero), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst no done", 32'(done_cnt - d0), 32'(0));
        run_op(8'h22, 8'h11, 8'h11, 1'b0, 1'b0, "post-reset");
        run_op(8'h80, 8'h81, 8'hFF, 1'b1, 1'b0, "80-81");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes a − b one bit per clock, LSB first, with a single borrow flip-flop.
- It is the inverse-direction companion to the combinational ripple adder used in the datapath.
- Used in the vital-sign processing path for threshold and delta computations (e.g. current − previous sample), where area matters more than latency.
- Start/done handshake. Result held until the next operation completes.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when diff/borrow/zero are updated
- diff  out  WIDTH  (a − b) mod 2^WIDTH
- borrow  out  1  1 when a < b (unsigned)
- zero  out  1  1 when diff == 0

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - FSM returns to IDLE.
  - busy=0, done=0, diff=0, borrow=0, zero=0.
  - Internal shift registers, bit counter and borrow flip-flop are cleared.
  - Any in-flight operation is abandoned and produces no done pulse.
- FSM states:
  - IDLE:
    - start=1 → latch a into A_sh, b into B_sh; br=0; cnt=0; go to SHIFT.
    - Otherwise remain.
  - SHIFT: on each clock:
    - a0=A_sh[0], b0=B_sh[0].
    - d = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
    - R_sh shifts right with d entering at MSB; A_sh and B_sh shift right.
    - cnt increments.
    - When cnt reaches WIDTH−1 (last bit processed on this edge) → go to DONE.
  - DONE (one cycle):
    - done=1.
    - diff=R_sh, borrow=br, zero=(R_sh==0); these registers are loaded at the entry edge.
    - start=1 → accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation).
    - Otherwise → IDLE.
- busy=1 in SHIFT only; busy=0 in IDLE and DONE.
- Timing: start accepted at edge k → busy=1 after edge k, SHIFT occupies WIDTH cycles, done=1 after edge k+WIDTH for exactly one cycle.
- Latency: WIDTH+1 cycles from start edge to result visible. Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. a and b may change freely after the accepting edge.
- diff, borrow and zero update only on entry to DONE. They hold their values through IDLE and through the next SHIFT phase.
- Arithmetic:
  - Modulo 2^WIDTH; no signed interpretation.
  - borrow equals the final borrow out of the MSB, i.e. a < b.
  - a == b gives diff=0, borrow=0, zero=1.
- The counter must be ceil(log2(WIDTH)) bits wide and must not wrap before WIDTH−1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start at edge 0 → busy=1 for edges 1–8; done=1 after edge 8 only; diff=0x02, borrow=0, zero=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, zero=0; a=0x00, b=0xFF → diff=0x01, borrow=1.
- a=0xA5, b=0xA5 → diff=0x00, borrow=0, zero=1; a=0xFF, b=0x00 → diff=0xFF, borrow=0.
- Start 0x10−0x01, pulse start with a=0x00, b=0x00 at edge 4, change a/b mid-operation → ignored; result 0x0F, borrow=0; exactly one done pulse.
- Start held high through DONE with next operands 0x80−0x81 → second operation begins with no IDLE cycle; second done 9 cycles after the first; diff=0xFF, borrow=1; first result held until then.
- rst_n low at edge 5 of an operation → busy, done, diff, borrow and zero all 0 immediately (asynchronously); no done pulse; a fresh start after release produces the correct result.
